// File: rtl/imem_loader_pkg.sv
// ---------------------------------------------------------------------------
// imem_loader_pkg
//   Shared definitions for the instruction-memory boot loader:
//   - state_e        : loader FSM states
//   - BYTES_PER_WORD : stream bytes packed into one memory word
//   - LANE_W         : width of the byte-lane counter
//   - is_last_lane() : true when a lane index is the top byte of a word
// ---------------------------------------------------------------------------
package imem_loader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int BYTES_PER_WORD = 4;
    localparam int LANE_W         = 2;

    function automatic logic is_last_lane(input logic [LANE_W-1:0] lane);
        return lane == LANE_W'(BYTES_PER_WORD - 1);
    endfunction

endpackage : imem_loader_pkg

// File: rtl/imem_loader_if.sv
// ---------------------------------------------------------------------------
// imem_loader_if
//   Bundles the byte-stream handshake and the instruction-memory write port
//   seen by the loader.
//   Signals:
//     byte_valid / byte_data / byte_ready : byte stream, transfer on
//                                           valid && ready at a rising edge
//     mem_we / mem_addr / mem_wdata       : one-cycle word write strobe,
//                                           word address and write data
//   Modports:
//     master : stream source / memory observer (host side)
//     slave  : the loader itself
// ---------------------------------------------------------------------------
interface imem_loader_if #(
    parameter int ADDR_WIDTH = 11
);
    import imem_loader_pkg::*;

    logic                  byte_valid;
    logic [7:0]            byte_data;
    logic                  byte_ready;

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;

    modport master (
        output byte_valid, byte_data,
        input  byte_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  byte_valid, byte_data,
        output byte_ready, mem_we, mem_addr, mem_wdata
    );

endinterface : imem_loader_if

// File: rtl/imem_loader_byte_packer.sv
// ---------------------------------------------------------------------------
// byte_packer
//   Lane counter plus 32-bit little-endian assembly register. The first byte
//   after a clear lands in bits [7:0]; the lane wraps from 3 back to 0.
//   Ports:
//     clk             : clock
//     rst             : synchronous active-high reset
//     clear_i         : drop any partial word and restart at lane 0
//     push_i          : a byte is accepted this cycle
//     byte_i          : the byte being accepted
//     word_o          : assembled word including the byte pushed this cycle,
//                       so it is complete in the same cycle as word_complete_o
//     word_complete_o : this push fills the top lane of the word
// ---------------------------------------------------------------------------
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear_i,
    input  logic        push_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_complete_o
);

    logic [LANE_W-1:0] lane_q, lane_d;
    logic [31:0]       word_q, word_d;

    always_comb begin
        // NOTE: every variable written here gets a default first, so no
        // path leaves it unassigned and no latch is inferred.
        lane_d = lane_q;
        word_d = word_q;
        if (clear_i) begin
            lane_d = '0;
            word_d = '0;
        end else if (push_i) begin
            // {lane, 3'b000} is lane*8: the bit offset of this byte lane.
            word_d[{lane_q, 3'b000} +: 8] = byte_i;
            // Two-bit counter wraps from 3 to 0 by itself.
            lane_d = lane_q + LANE_W'(1);
        end
    end

    // The next-state value already holds the merged byte, which lets the
    // caller register a complete word at the same edge as the last push.
    assign word_o          = word_d;
    assign word_complete_o = push_i && !clear_i && is_last_lane(lane_q);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            lane_q <= '0;
            word_q <= '0;
        end else begin
            lane_q <= lane_d;
            word_q <= word_d;
        end
    end

endmodule : byte_packer

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//   Boot-time writer for the SCPU instruction memory. Packs a byte stream
//   into little-endian 32-bit words, writes them to consecutive word
//   addresses from 0, keeps the CPU in reset until the load is complete and
//   keeps a modulo-2^32 checksum of the words written.
//   Ports:
//     clk          : system clock
//     rst          : synchronous active-high reset
//     start_i      : one-cycle pulse starting a load (honoured in IDLE only)
//     word_count_i : words to load, sampled on start; 0 or > DEPTH => DEPTH
//     bus          : byte stream in, memory write port out (slave modport)
//     busy_o       : load in progress (LOAD or FLUSH)
//     done_o       : load complete (terminal until reset)
//     cpu_hold_o   : CPU reset request, released only in DONE
//     checksum_o   : sum of all words written during this load
// ---------------------------------------------------------------------------
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 11,
    parameter int DEPTH      = 2048
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH:0]   word_count_i,
    imem_loader_if.slave          bus,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  cpu_hold_o,
    output logic [31:0]           checksum_o
);

    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] IDX_ONE = (ADDR_WIDTH + 1)'(1);

    state_e                state_q, state_d;
    // One bit wider than the address so reaching DEPTH words never wraps.
    logic [ADDR_WIDTH:0]   word_idx_q, word_idx_d;
    logic [ADDR_WIDTH:0]   target_q, target_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]           mem_wdata_q, mem_wdata_d;
    logic [31:0]           checksum_q, checksum_d;

    logic                  byte_ready;
    logic                  accept;
    logic                  pack_clear;
    logic [31:0]           pack_word;
    logic                  pack_complete;
    logic [ADDR_WIDTH:0]   word_idx_inc;

    // Ready depends on state alone, never on byte_valid.
    assign byte_ready   = (state_q == LOAD);
    assign accept       = byte_ready && bus.byte_valid;
    assign word_idx_inc = word_idx_q + IDX_ONE;

    byte_packer u_packer (
        .clk             (clk),
        .rst             (rst),
        .clear_i         (pack_clear),
        .push_i          (accept),
        .byte_i          (bus.byte_data),
        .word_o          (pack_word),
        .word_complete_o (pack_complete)
    );

    always_comb begin
        state_d     = state_q;
        word_idx_d  = word_idx_q;
        target_d    = target_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        checksum_d  = checksum_q;
        pack_clear  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (word_count_i == '0 || word_count_i > DEPTH_W) begin
                        target_d = DEPTH_W;
                    end else begin
                        target_d = word_count_i;
                    end
                    word_idx_d = '0;
                    checksum_d = '0;
                    pack_clear = 1'b1;
                    state_d    = LOAD;
                end
            end

            LOAD: begin
                // The write registers load at the lane-3 handshake edge, so
                // the strobe appears in the following cycle. The packer keeps
                // accepting bytes for the next word meanwhile.
                if (pack_complete) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = word_idx_q[ADDR_WIDTH-1:0];
                    mem_wdata_d = pack_word;
                    checksum_d  = checksum_q + pack_word;
                    word_idx_d  = word_idx_inc;
                    if (word_idx_inc == target_q) begin
                        state_d = FLUSH;
                    end
                end
            end

            // The final write is on the bus during FLUSH.
            FLUSH: state_d = DONE;

            DONE: state_d = DONE;

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            word_idx_q  <= '0;
            target_q    <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            checksum_q  <= '0;
        end else begin
            state_q     <= state_d;
            word_idx_q  <= word_idx_d;
            target_q    <= target_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            checksum_q  <= checksum_d;
        end
    end

    assign bus.byte_ready = byte_ready;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;

    assign busy_o     = (state_q == LOAD) || (state_q == FLUSH);
    assign done_o     = (state_q == DONE);
    assign cpu_hold_o = (state_q != DONE);
    assign checksum_o = checksum_q;

endmodule : imem_loader
